// File: rtl/sys_defs.sv
// sys_defs: shared CDB packet layout, default sizing and round-robin helper
package sys_defs;
  localparam int XLEN = 32;
  localparam int DEF_NUM_LANES = 2;
  localparam int DEF_BUF_DEPTH = 2;
  localparam int DEF_PRF_IDX_W = 6;
  localparam int DEF_ROB_IDX_W = 5;
  typedef struct packed {
    logic take_branch;
    logic [DEF_ROB_IDX_W-1:0] rob_idx;
    logic [DEF_PRF_IDX_W-1:0] dest_prf;
    logic [XLEN-1:0] value;
  } CDB_PACKET;
  function automatic int rr_succ(input int g, input int n);
    return (g + 1) % n;
  endfunction
endpackage

// File: rtl/cdb_lane_fifo.sv
// cdb_lane_fifo: per-lane result buffer, power-of-two depth with wrapping pointers
module cdb_lane_fifo
  import sys_defs::*;
#(
  parameter int DEPTH = DEF_BUF_DEPTH,
  parameter int W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [$clog2(DEPTH):0] count,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  // storage needs no reset; only valid entries are ever read out
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= din;
  // pointers and occupancy; flush empties the lane like reset does
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter over buffered execute lanes; define CDB_BYPASS_EN for same-cycle bypass of empty lanes
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int PRF_IDX_W = DEF_PRF_IDX_W,
  parameter int ROB_IDX_W = DEF_ROB_IDX_W
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic [NUM_LANES-1:0] ex_valid,
  input  logic [NUM_LANES*32-1:0] ex_result,
  input  logic [NUM_LANES*PRF_IDX_W-1:0] ex_dest_prf,
  input  logic [NUM_LANES*ROB_IDX_W-1:0] ex_rob_idx,
  input  logic [NUM_LANES-1:0] ex_take_branch,
  output logic [NUM_LANES-1:0] cdb_hazard,
  output logic cdb_valid,
  output logic [31:0] cdb_value,
  output logic [PRF_IDX_W-1:0] cdb_dest_prf,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic cdb_take_branch
);
  localparam int PKT_W = 32 + PRF_IDX_W + ROB_IDX_W + 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int RR_W = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  logic [PKT_W-1:0] ex_pkt [NUM_LANES];
  logic [PKT_W-1:0] head [NUM_LANES];
  logic [PKT_W-1:0] cand [NUM_LANES];
  logic [CNT_W-1:0] count [NUM_LANES];
  logic [NUM_LANES-1:0] full, accept, nonempty, req, push, pop;
  logic [RR_W-1:0] rr_ptr, gnt_idx;
  logic gnt_found, gnt_fire;
  logic [PKT_W-1:0] gnt_pkt;
  assign cdb_hazard = full;
  assign gnt_fire = gnt_found & ~flush;
  assign gnt_pkt = cand[gnt_idx];
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign ex_pkt[i] = {ex_take_branch[i], ex_rob_idx[i*ROB_IDX_W +: ROB_IDX_W],
                        ex_dest_prf[i*PRF_IDX_W +: PRF_IDX_W], ex_result[i*32 +: 32]};
    assign nonempty[i] = count[i] != '0;
    assign accept[i] = ex_valid[i] & ~full[i] & ~flush;
    assign pop[i] = gnt_fire & (gnt_idx == RR_W'(i)) & nonempty[i];
`ifdef CDB_BYPASS_EN
    assign req[i] = nonempty[i] | accept[i];
    assign cand[i] = nonempty[i] ? head[i] : ex_pkt[i];
    assign push[i] = accept[i] & ~(gnt_fire & (gnt_idx == RR_W'(i)) & ~nonempty[i]);
`else
    assign req[i] = nonempty[i];
    assign cand[i] = head[i];
    assign push[i] = accept[i];
`endif
    cdb_lane_fifo #(.DEPTH(BUF_DEPTH), .W(PKT_W)) u_fifo (
      .clock(clock),
      .reset(reset),
      .flush(flush),
      .push(push[i]),
      .pop(pop[i]),
      .din(ex_pkt[i]),
      .head(head[i]),
      .count(count[i]),
      .full(full[i])
    );
  end
  // first requesting lane at or after rr_ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_LANES; k++)
      if (!gnt_found && req[(int'(rr_ptr) + k) % NUM_LANES]) begin
        gnt_found = 1'b1;
        gnt_idx = RR_W'((int'(rr_ptr) + k) % NUM_LANES);
      end
  end
  // pointer advances past the winner only when a grant actually fires
  always_ff @(posedge clock)
    if (reset) rr_ptr <= '0;
    else if (gnt_fire) rr_ptr <= RR_W'(rr_succ(int'(gnt_idx), NUM_LANES));
  // registered broadcast; data holds when nothing is granted
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      {cdb_take_branch, cdb_rob_idx, cdb_dest_prf, cdb_value} <= '0;
    end else begin
      cdb_valid <= gnt_fire;
      if (gnt_fire) {cdb_take_branch, cdb_rob_idx, cdb_dest_prf, cdb_value} <= gnt_pkt;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus randomized run against a queue-based model
module tb_cdb_arbiter;
  localparam int NL = 2;
  localparam int D = 2;
  typedef struct packed {
    logic tb;
    logic [4:0] rob;
    logic [5:0] prf;
    logic [31:0] value;
  } pkt_t;
  typedef struct {
    bit rst;
    bit fl;
    bit [1:0] v;
    logic [31:0] v0;
    logic [5:0] p0;
    logic [4:0] r0;
    logic [31:0] v1;
    bit ev;
    logic [31:0] eval;
    logic [1:0] ehaz;
  } vec_t;
  logic clock = 1'b0;
  logic reset, flush;
  logic [NL-1:0] ex_valid, ex_take_branch, cdb_hazard;
  logic [NL*32-1:0] ex_result;
  logic [NL*6-1:0] ex_dest_prf;
  logic [NL*5-1:0] ex_rob_idx;
  logic cdb_valid, cdb_take_branch;
  logic [31:0] cdb_value;
  logic [5:0] cdb_dest_prf;
  logic [4:0] cdb_rob_idx;
  int checks = 0;
  int errors = 0;
  pkt_t q[NL][$];
  int rr = 0;
  bit m_valid = 0;
  pkt_t m_out = '0;
  cdb_arbiter #(.NUM_LANES(NL), .BUF_DEPTH(D), .PRF_IDX_W(6), .ROB_IDX_W(5)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .ex_valid(ex_valid),
    .ex_result(ex_result),
    .ex_dest_prf(ex_dest_prf),
    .ex_rob_idx(ex_rob_idx),
    .ex_take_branch(ex_take_branch),
    .cdb_hazard(cdb_hazard),
    .cdb_valid(cdb_valid),
    .cdb_value(cdb_value),
    .cdb_dest_prf(cdb_dest_prf),
    .cdb_rob_idx(cdb_rob_idx),
    .cdb_take_branch(cdb_take_branch)
  );
  always #5 clock = ~clock;
  function automatic pkt_t mk(input logic [31:0] v, input logic [5:0] p, input logic [4:0] r);
    pkt_t x;
    x.value = v;
    x.prf = p;
    x.rob = r;
    x.tb = v[0];
    return x;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: one broadcast per cycle chosen round-robin from lane queues
  task automatic model(input bit rst, input bit fl, input bit [1:0] v, input pkt_t p0, input pkt_t p1);
    pkt_t p[NL];
    bit acc[NL];
    int g;
    p[0] = p0;
    p[1] = p1;
    for (int i = 0; i < NL; i++) acc[i] = v[i] && q[i].size() < D && !fl;
    if (rst) begin
      for (int i = 0; i < NL; i++) q[i].delete();
      rr = 0;
      m_valid = 0;
      m_out = '0;
    end else if (fl) begin
      for (int i = 0; i < NL; i++) q[i].delete();
      m_valid = 0;
    end else begin
      g = -1;
      for (int k = 0; k < NL; k++) begin
        int j;
        j = (rr + k) % NL;
`ifdef CDB_BYPASS_EN
        if (g < 0 && (q[j].size() > 0 || acc[j])) g = j;
`else
        if (g < 0 && q[j].size() > 0) g = j;
`endif
      end
      m_valid = g >= 0;
      if (g >= 0) begin
        if (q[g].size() > 0) m_out = q[g].pop_front();
        else begin
          m_out = p[g];
          acc[g] = 0;
        end
        rr = (g + 1) % NL;
      end
      for (int i = 0; i < NL; i++) if (acc[i]) q[i].push_back(p[i]);
    end
  endtask
  task automatic step(input bit rst, input bit fl, input bit [1:0] v, input pkt_t p0, input pkt_t p1);
    reset = rst;
    flush = fl;
    ex_valid = v;
    ex_result = {p1.value, p0.value};
    ex_dest_prf = {p1.prf, p0.prf};
    ex_rob_idx = {p1.rob, p0.rob};
    ex_take_branch = {p1.tb, p0.tb};
    @(posedge clock);
    model(rst, fl, v, p0, p1);
    #1;
    chk("valid", cdb_valid, m_valid);
    chk("value", cdb_value, m_out.value);
    chk("dest_prf", cdb_dest_prf, m_out.prf);
    chk("rob_idx", cdb_rob_idx, m_out.rob);
    chk("take_branch", cdb_take_branch, m_out.tb);
    chk("hazard", cdb_hazard, {q[1].size() == D, q[0].size() == D});
  endtask
  initial begin
    vec_t tbl[$];
    pkt_t rp0, rp1;
    bit [1:0] rv;
    step(1, 0, 2'b00, '0, '0);
    step(1, 0, 2'b00, '0, '0);
    chk("reset_valid", cdb_valid, 1'b0);
    chk("reset_value", cdb_value, 32'h0);
    chk("reset_hazard", cdb_hazard, 2'b00);
`ifndef CDB_BYPASS_EN
    tbl.push_back('{0, 0, 2'b01, 32'h1234, 6'd5, 5'd3, 32'h0, 0, 32'h0, 2'b00});
    tbl.push_back('{0, 0, 2'b00, 32'h0, 6'd0, 5'd0, 32'h0, 1, 32'h1234, 2'b00});
    tbl.push_back('{0, 0, 2'b11, 32'hB0, 6'd1, 5'd1, 32'hA1, 0, 32'h1234, 2'b00});
    tbl.push_back('{0, 0, 2'b10, 32'h0, 6'd0, 5'd0, 32'hA2, 1, 32'hA1, 2'b00});
    tbl.push_back('{0, 0, 2'b10, 32'h0, 6'd0, 5'd0, 32'hA3, 1, 32'hB0, 2'b10});
    tbl.push_back('{0, 0, 2'b10, 32'h0, 6'd0, 5'd0, 32'hA4, 1, 32'hA2, 2'b00});
    tbl.push_back('{0, 0, 2'b10, 32'h0, 6'd0, 5'd0, 32'hA4, 1, 32'hA3, 2'b00});
    tbl.push_back('{0, 0, 2'b00, 32'h0, 6'd0, 5'd0, 32'h0, 1, 32'hA4, 2'b00});
    tbl.push_back('{0, 0, 2'b00, 32'h0, 6'd0, 5'd0, 32'h0, 0, 32'hA4, 2'b00});
    tbl.push_back('{0, 0, 2'b11, 32'hC0, 6'd2, 5'd2, 32'hD0, 0, 32'hA4, 2'b00});
    tbl.push_back('{0, 0, 2'b11, 32'hC1, 6'd3, 5'd3, 32'hD1, 1, 32'hC0, 2'b10});
    tbl.push_back('{0, 0, 2'b01, 32'hC2, 6'd4, 5'd4, 32'h0, 1, 32'hD0, 2'b01});
    tbl.push_back('{0, 1, 2'b11, 32'hE0, 6'd5, 5'd5, 32'hE1, 0, 32'hD0, 2'b00});
    tbl.push_back('{0, 0, 2'b00, 32'h0, 6'd0, 5'd0, 32'h0, 0, 32'hD0, 2'b00});
    tbl.push_back('{0, 0, 2'b11, 32'hF0, 6'd6, 5'd6, 32'h90, 0, 32'hD0, 2'b00});
    tbl.push_back('{0, 0, 2'b11, 32'hF1, 6'd7, 5'd7, 32'h91, 1, 32'hF0, 2'b10});
    tbl.push_back('{0, 0, 2'b01, 32'hF2, 6'd8, 5'd8, 32'h0, 1, 32'h90, 2'b01});
    tbl.push_back('{1, 0, 2'b00, 32'h0, 6'd0, 5'd0, 32'h0, 0, 32'h0, 2'b00});
    tbl.push_back('{0, 0, 2'b01, 32'h77, 6'd9, 5'd9, 32'h0, 0, 32'h0, 2'b00});
    tbl.push_back('{0, 0, 2'b00, 32'h0, 6'd0, 5'd0, 32'h0, 1, 32'h77, 2'b00});
    tbl.push_back('{0, 0, 2'b00, 32'h0, 6'd0, 5'd0, 32'h0, 0, 32'h77, 2'b00});
    foreach (tbl[n]) begin
      step(tbl[n].rst, tbl[n].fl, tbl[n].v, mk(tbl[n].v0, tbl[n].p0, tbl[n].r0),
           mk(tbl[n].v1, tbl[n].v1[5:0], tbl[n].v1[4:0]));
      chk($sformatf("vec%0d_valid", n), cdb_valid, tbl[n].ev);
      chk($sformatf("vec%0d_value", n), cdb_value, tbl[n].eval);
      chk($sformatf("vec%0d_hazard", n), cdb_hazard, tbl[n].ehaz);
      if (n == 1) begin
        chk("single_prf", cdb_dest_prf, 6'd5);
        chk("single_rob", cdb_rob_idx, 5'd3);
      end
    end
`else
    step(0, 0, 2'b01, mk(32'hBEEF, 6'd1, 5'd2), '0);
    chk("bypass_valid", cdb_valid, 1'b1);
    chk("bypass_value", cdb_value, 32'hBEEF);
    chk("bypass_hazard", cdb_hazard, 2'b00);
    step(0, 0, 2'b00, '0, '0);
    chk("bypass_idle_valid", cdb_valid, 1'b0);
`endif
    rv = '0;
    rp0 = '0;
    rp1 = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!(rv[0] && q[0].size() == D)) begin
        rv[0] = $urandom_range(0, 2) != 0;
        rp0 = mk($urandom, 6'($urandom), 5'($urandom));
      end
      if (!(rv[1] && q[1].size() == D)) begin
        rv[1] = $urandom_range(0, 2) != 0;
        rp1 = mk($urandom, 6'($urandom), 5'($urandom));
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, rv, rp0, rp1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
